// File: rtl/dfr_input_scheduler_if.sv
// Sample-in / node-state-out stream bundle for the reservoir input scheduler.
// The master modport is the scheduler side; slave is the source/sink side.
interface dfr_input_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 4
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [IDX_W-1:0]      m_index;
    logic                  m_last;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_index, m_last
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_index, m_last
    );
endinterface

// File: rtl/dfr_input_scheduler.sv
// Delayed-feedback reservoir input scheduler: masks one sample per virtual node,
// drives the reservoir advance/clear and captures tail-node states as a stream.
module dfr_input_scheduler #(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int FRAC_BITS     = 16,
    parameter int IDX_W         = $clog2(VIRTUAL_NODES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  mask_wr_en,
    input  logic [IDX_W-1:0]      mask_wr_addr,
    input  logic [DATA_WIDTH-1:0] mask_wr_data,
    output logic [DATA_WIDTH-1:0] res_din,
    output logic                  res_en,
    output logic                  res_clr,
    input  logic [DATA_WIDTH-1:0] res_dout,
    output logic                  busy,
    dfr_input_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, INJECT} state_t;

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(VIRTUAL_NODES - 1);

    state_t                        state;
    logic [IDX_W-1:0]              k;
    logic signed [DATA_WIDTH-1:0]  sample;
    logic signed [DATA_WIDTH-1:0]  mask [VIRTUAL_NODES];

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [2*DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0]          inj;

    assign prod    = sample * mask[k];
    assign shifted = prod >>> FRAC_BITS;

    // Result fits when the bits above the target sign bit are a pure sign extension.
    always_comb begin
        inj = shifted[DATA_WIDTH-1:0];
        if (!((&shifted[2*DATA_WIDTH-1:DATA_WIDTH-1]) || !(|shifted[2*DATA_WIDTH-1:DATA_WIDTH-1])))
            inj = shifted[2*DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    assign res_en  = (state == INJECT) && (!bus.m_valid || bus.m_ready);
    assign res_din = (state == INJECT) ? inj : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            k           <= '0;
            sample      <= '0;
            for (int i = 0; i < VIRTUAL_NODES; i++) mask[i] <= '0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b0;
            res_clr     <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_index <= '0;
            bus.m_last  <= 1'b0;
        end else begin
            res_clr <= 1'b0;

            // Mask is frozen while a sample is in flight.
            if (state == IDLE && mask_wr_en && mask_wr_addr <= LAST_K)
                mask[mask_wr_addr] <= mask_wr_data;

            case (state)
                IDLE: begin
                    if (clear) begin
                        state       <= CLEAR;
                        res_clr     <= 1'b1;
                        bus.s_ready <= 1'b0;
                        busy        <= 1'b1;
                    end else if (bus.s_valid) begin
                        state       <= INJECT;
                        sample      <= bus.s_data;
                        k           <= '0;
                        bus.s_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                CLEAR: begin
                    state       <= IDLE;
                    bus.s_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                INJECT: begin
                    if (res_en) begin
                        k <= k + 1'b1;
                        if (k == LAST_K) begin
                            state       <= IDLE;
                            k           <= '0;
                            bus.s_ready <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.s_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase

            if (res_en) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= res_dout;
                bus.m_index <= k;
                bus.m_last  <= (k == LAST_K);
            end else if (bus.m_valid && bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dfr_input_scheduler.sv
// Scoreboard bench: stimulus queues expected node states and reservoir inputs,
// a negedge monitor pops and compares them as the scheduler produces them.
module tb_dfr_input_scheduler;
    localparam int VN = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } out_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          mask_wr_en = 1'b0;
    logic [IW-1:0] mask_wr_addr = '0;
    logic [DW-1:0] mask_wr_data = '0;
    logic [DW-1:0] res_din;
    logic          res_en;
    logic          res_clr;
    logic [DW-1:0] res_dout;
    logic          busy;
    logic [DW-1:0] cyc = '0;

    dfr_input_scheduler_if #(.DATA_WIDTH(DW), .IDX_W(IW)) bus ();

    dfr_input_scheduler #(.VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .FRAC_BITS(16)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .mask_wr_en(mask_wr_en), .mask_wr_addr(mask_wr_addr), .mask_wr_data(mask_wr_data),
        .res_din(res_din), .res_en(res_en), .res_clr(res_clr), .res_dout(res_dout),
        .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign res_dout = cyc;

    int checks = 0;
    int errors = 0;
    out_t          out_q[$];
    logic [DW-1:0] din_q[$];
    logic [DW-1:0] tab [VN];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: reservoir input on every advance, node state on every output handshake.
    always @(negedge clk) begin
        if (res_en === 1'b1) begin
            if (din_q.size() == 0) chk("unexpected_res_en", 1, 0);
            else chk("res_din", res_din, din_q.pop_front());
        end
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            if (out_q.size() == 0) chk("unexpected_m_valid", 1, 0);
            else begin
                out_t e;
                e = out_q.pop_front();
                chk("m_data", bus.m_data, e.data);
                chk("m_index", bus.m_index, e.idx);
                chk("m_last", bus.m_last, e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [IW-1:0] a, input logic [DW-1:0] d);
        mask_wr_en = 1'b1; mask_wr_addr = a; mask_wr_data = d;
        tick();
        mask_wr_en = 1'b0;
    endtask

    // Runs one sample from IDLE; stall_len cycles of m_ready=0 just before node stall_k.
    // Clear and a mask write are held high throughout INJECT and must be ignored.
    task automatic run_sample(input logic [DW-1:0] s, input int stall_k, input int stall_len);
        logic [DW-1:0] c0;
        int en, c, st;
        bus.s_valid = 1'b1; bus.s_data = s;
        #1;
        chk("s_ready_idle", bus.s_ready, 1);
        tick();
        bus.s_valid = 1'b0;
        c0 = cyc;
        chk("busy_inject", busy, 1);
        for (int j = 0; j < VN; j++) begin
            out_t e;
            e.data = c0 + DW'(j) + ((j >= stall_k) ? DW'(stall_len) : '0);
            e.idx  = IW'(j);
            e.last = (j == VN - 1);
            out_q.push_back(e);
            din_q.push_back(tab[j]);
        end
        en = 0; c = 0; st = 0;
        clear = 1'b1;
        mask_wr_en = 1'b1; mask_wr_addr = '0; mask_wr_data = 32'h7FFF_FFFF;
        while (en < VN && c < 60) begin
            if (en == stall_k && st < stall_len) begin
                bus.m_ready = 1'b0;
                #1;
                chk("stall_res_en", res_en, 0);
                chk("stall_res_din", res_din, tab[stall_k]);
                chk("stall_m_index", bus.m_index, IW'(stall_k - 1));
                chk("stall_m_data", bus.m_data, c0 + DW'(stall_k - 1));
                st++;
            end else begin
                bus.m_ready = 1'b1;
                #1;
                if (res_en) en++;
            end
            chk("no_clr_in_inject", res_clr, 0);
            c++;
            tick();
        end
        clear = 1'b0; mask_wr_en = 1'b0; bus.m_ready = 1'b1;
        chk("inject_cycles", c, VN + stall_len);
        chk("s_ready_after", bus.s_ready, 1);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        bus.s_valid = 1'b1; bus.s_data = 32'h1234_5678; bus.m_ready = 1'b1;
        clear = 1'b1;
        tick(); tick();
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_clr", res_clr, 0);
        chk("rst_res_en", res_en, 0);
        chk("rst_res_din", res_din, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_index", bus.m_index, 0);
        chk("rst_m_last", bus.m_last, 0);
        rst = 1'b1; bus.s_valid = 1'b0; clear = 1'b0;
        #1;
        chk("rel_s_ready", bus.s_ready, 1);
        chk("rel_busy", busy, 0);

        write_mask(4'd0, 32'h0000_8000);
        write_mask(4'd1, 32'h0002_0000);
        write_mask(4'd2, 32'hFFFF_0000);
        write_mask(4'd12, 32'h1111_1111);
        for (int j = 0; j < VN; j++) tab[j] = '0;

        tab[0] = 32'h0001_0000; tab[1] = 32'h0004_0000; tab[2] = 32'hFFFE_0000;
        run_sample(32'h0002_0000, VN, 0);

        tab[0] = 32'h3FFF_8000; tab[1] = 32'h7FFF_FFFF; tab[2] = 32'h8001_0000;
        run_sample(32'h7FFF_0000, 4, 3);

        // Clear and sample together: clear wins, sample taken on the next IDLE cycle.
        clear = 1'b1; bus.s_valid = 1'b1; bus.s_data = 32'h8000_0000;
        tick();
        clear = 1'b0; bus.s_valid = 1'b0;
        chk("clr_pulse", res_clr, 1);
        chk("clr_no_accept_busy", busy, 1);
        chk("clr_s_ready", bus.s_ready, 0);
        tick();
        chk("clr_one_cycle", res_clr, 0);
        chk("clr_back_idle", busy, 0);
        tab[0] = 32'hC000_0000; tab[1] = 32'h8000_0000; tab[2] = 32'h7FFF_FFFF;
        run_sample(32'h8000_0000, VN, 0);

        // Reset while k=6: nodes 0..5 are delivered, node 6 advances but never emerges.
        bus.s_valid = 1'b1; bus.s_data = 32'h0002_0000;
        tick();
        bus.s_valid = 1'b0;
        begin
            logic [DW-1:0] c0;
            c0 = cyc;
            for (int j = 0; j < 6; j++) begin
                out_t e;
                e.data = c0 + DW'(j); e.idx = IW'(j); e.last = 1'b0;
                out_q.push_back(e);
            end
        end
        din_q.push_back(32'h0001_0000); din_q.push_back(32'h0004_0000);
        din_q.push_back(32'hFFFE_0000);
        for (int j = 3; j < 7; j++) din_q.push_back('0);
        for (int j = 0; j < 6; j++) tick();
        rst = 1'b0;
        tick();
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_res_en", res_en, 0);
        rst = 1'b1;
        for (int j = 0; j < VN; j++) tab[j] = '0;
        run_sample(32'h0002_0000, VN, 0);

        tick();
        chk("out_q_drained", out_q.size(), 0);
        chk("din_q_drained", din_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dfr_input_scheduler.md
# dfr_input_scheduler

Sequences one delayed-feedback reservoir: accepts input samples over a valid/ready stream, applies a per-virtual-node fixed-point input mask, and drives the masked values into the reservoir one virtual node per enabled cycle. It also captures each tail-node state as the reservoir advances and presents it on an output stream with node index and end-of-sample marker. It sits between the sample source and the reservoir datapath, and owns the reservoir's advance-enable and clear.

## Interface
- VIRTUAL_NODES, 10, nodes per sample; mask depth; must be ≥2
- DATA_WIDTH, 32, signed two's-complement sample/mask/state width
- FRAC_BITS, 16, fractional bits of the fixed-point format (< DATA_WIDTH)
- IDX_W, $clog2(VIRTUAL_NODES), width of node index/mask address (derived)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- clear  in  1  request reservoir clear; honoured only in IDLE
- s_valid  in  1  input sample valid
- s_ready  out  1  scheduler can accept a sample
- s_data  in  DATA_WIDTH  input sample
- mask_wr_en  in  1  mask write strobe
- mask_wr_addr  in  IDX_W  mask entry index
- mask_wr_data  in  DATA_WIDTH  mask value
- res_din  out  DATA_WIDTH  masked value into reservoir
- res_en  out  1  reservoir advance enable (one node shift per cycle high)
- res_clr  out  1  one-cycle synchronous clear of all reservoir nodes
- res_dout  in  DATA_WIDTH  reservoir tail-node output
- m_valid  out  1  captured node state valid
- m_ready  in  1  downstream accepts
- m_data  out  DATA_WIDTH  captured node state
- m_index  out  IDX_W  virtual-node index of m_data
- m_last  out  1  m_data is node VIRTUAL_NODES-1 of the sample
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CLEAR, INJECT.
- IDLE: s_ready=1. clear=1 → CLEAR (clear has priority over s_valid; sample not accepted that cycle). Else s_valid=1 → latch s_data into sample register, node index k←0, → INJECT.
- CLEAR: res_clr=1 for exactly one cycle, → IDLE. Output register unaffected.
- INJECT: res_din = sat((sample × mask[k]) >>> FRAC_BITS); full 2·DATA_WIDTH signed product, arithmetic shift, saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. res_din is 0 outside INJECT.
- res_en = (state==INJECT) && (!m_valid || m_ready). Cycle with res_en: output register loads m_data←res_dout, m_index←k, m_last←(k==VIRTUAL_NODES−1), m_valid←1; k increments; at k==VIRTUAL_NODES−1 → IDLE.
- No res_en and m_valid && m_ready: m_valid←0. res_en stalls (reservoir frozen, k held) while output is full and not accepted.
- Mask writes accepted only when busy=0; writes while busy or with mask_wr_addr ≥ VIRTUAL_NODES are ignored. A write and a sample accept in the same IDLE cycle are both performed; the sample uses the new mask from node 0 onward.
- clear outside IDLE is ignored (not queued).

## Timing
- Reset (rst=0 at edge): state IDLE, k=0, all mask entries 0, sample 0; outputs s_ready=1 after reset release, res_en=0, res_clr=0, res_din=0, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0. Reset mid-INJECT abandons the sample; no partial output survives.
- Sample accepted at edge t → INJECT from cycle t+1; first res_en at t+1 if output free.
- Unstalled: VIRTUAL_NODES INJECT cycles, then IDLE; sample-to-sample period VIRTUAL_NODES+1 cycles.
- m_data for node k valid the cycle after its res_en; m_valid held until m_ready.
- res_din, res_en combinational from state/registers and m_ready; all other outputs registered.

## Test plan
- Reset: hold rst=0 two cycles with s_valid=1, clear=1 → all outputs at reset values, no accept, res_clr=0; first cycle after release s_ready=1, busy=0.
- Mask arithmetic (DATA_WIDTH=32, FRAC_BITS=16): mask[0]=0x0000_8000, sample 0x0002_0000 → res_din 0x0001_0000 at k=0; mask[1]=0x0002_0000, sample 0x7FFF_0000 → 0x7FFF_FFFF; sample 0x8000_0000 × 0x0002_0000 → 0x8000_0000.
- Full sample, m_ready=1, res_dout = cycle counter → exactly 10 res_en cycles, m_index 0..9, m_last only at 9, m_data equals res_dout of each enabled cycle, next s_ready on 11th cycle.
- Backpressure: m_ready=0 for 3 cycles at k=4 → res_en low, res_din held, k stays 4, m_data/m_index unchanged; resumes with no lost or duplicated index.
- Clear arbitration: clear=1 and s_valid=1 in IDLE → one res_clr pulse, no accept, sample taken next cycle; clear during INJECT → no res_clr; mask write during INJECT → mask unchanged.
- Reset at k=6 mid-sample → m_valid=0, busy=0 next cycle; new sample restarts at m_index 0.
